// File: rtl/moving_avg_window.sv
// Sliding-window smoother: keeps the last DEPTH = 2**LOG2_DEPTH accepted samples,
// and registers the running window sum and the window average.
// A small FSM tracks how full the window is. out_valid pulses once per accept
// while the window holds a full set of samples.
// Optional build macro MOVING_AVG_ROUND_EN: q rounds half up instead of truncating.
module moving_avg_window #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOG2_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            d,
    input  logic                        clear,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            q,
    output logic [WIDTH+LOG2_DEPTH-1:0] sum,
    output logic                        filled
);

    localparam int unsigned DEPTH   = 1 << LOG2_DEPTH;
    localparam int unsigned SW      = WIDTH + LOG2_DEPTH;
    localparam int unsigned CW      = LOG2_DEPTH + 1;
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    typedef enum logic [1:0] {StEmpty, StFill, StFull} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] hist_q [DEPTH];
    logic [SW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic [SW-1:0]    sum_q;
    logic [WIDTH-1:0] avg_q;
    logic             out_valid_q;

    logic             accept;
    logic [SW-1:0]    acc_next;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] q_next;

    // Accept qualification, window arithmetic and saturating fill count.
    always_comb begin
        accept   = in_valid & ~clear;
        // hist entries are zero until written, so this is exact while filling.
        acc_next = acc_q + SW'(d) - SW'(hist_q[DEPTH-1]);
        cnt_inc  = (cnt_q == CntFull) ? CntFull : cnt_q + 1'b1;
    end

`ifdef MOVING_AVG_ROUND_EN
    logic [WIDTH:0] rnd;

    // (a + 2**(k-1)) >> k equals (a >> k) plus bit k-1 of a; one extra bit holds the carry.
    always_comb begin
        rnd = {1'b0, acc_next[SW-1:LOG2_DEPTH]} + (WIDTH + 1)'(acc_next[LOG2_DEPTH-1]);
        if (rnd[WIDTH]) begin
            q_next = '1;
        end else begin
            q_next = rnd[WIDTH-1:0];
        end
    end
`else
    // Truncating average: drop the low LOG2_DEPTH bits of the sum.
    always_comb begin
        q_next = acc_next[SW-1:LOG2_DEPTH];
    end
`endif

    // Fill-tracking FSM next state; clear wins over everything.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StEmpty;
        end else if (accept) begin
            unique case (state_q)
                StEmpty: state_d = (cnt_inc == CntFull) ? StFull : StFill;
                StFill:  state_d = (cnt_inc == CntFull) ? StFull : StFill;
                StFull:  state_d = StFull;
                default: state_d = StEmpty;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Window history, accumulator, fill count and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
            hist_q[0]   <= d;
            acc_q       <= acc_next;
            cnt_q       <= cnt_inc;
            sum_q       <= acc_next;
            avg_q       <= q_next;
            out_valid_q <= (cnt_inc == CntFull);
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign q         = avg_q;
    assign sum       = sum_q;
    assign filled    = (state_q == StFull);

endmodule

// File: tb/tb_moving_avg_window.sv
// Directed bench for moving_avg_window (WIDTH=8, LOG2_DEPTH=2).
// Every check compares {out_valid, filled, sum, q} against hand-computed values.
module tb_moving_avg_window;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] d;
    logic       clear;
    logic       out_valid;
    logic [7:0] q;
    logic [9:0] sum;
    logic       filled;

    int n_tests = 0;
    int n_fail  = 0;

    moving_avg_window #(
        .WIDTH      (8),
        .LOG2_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .d         (d),
        .clear     (clear),
        .out_valid (out_valid),
        .q         (q),
        .sum       (sum),
        .filled    (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected average for a window sum in the active build.
    function automatic logic [7:0] avg_of(input int s);
`ifdef MOVING_AVG_ROUND_EN
        int r;
        r = (s + 2) / 4;
        return (r > 255) ? 8'd255 : 8'(r);
`else
        return 8'(s / 4);
`endif
    endfunction

    function automatic logic [19:0] pack(input logic ov, input logic fl, input int s);
        return {ov, fl, 10'(s), avg_of(s)};
    endfunction

    // Apply inputs for one clock, then settle 1 time unit past the edge.
    task automatic drive(input logic v, input logic [7:0] dd, input logic c);
        in_valid = v;
        d        = dd;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [19:0] exp;
        rst_n = 1'b0;
        drive(1'b1, 8'd50, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        exp = pack(1'b0, 1'b0, 0);
        n_tests++;
        if ({out_valid, filled, sum, q} !== exp) begin
            n_fail++;
            $display("FAIL reset: got ov=%b fl=%b sum=%0d q=%0d, want %h", out_valid, filled,
                     sum, q, exp);
        end
        rst_n = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_fill;
        int sums [4] = '{1, 3, 6, 10};
        logic [19:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(i + 1), 1'b0);
            exp = pack(i == 3, i == 3, sums[i]);
            n_tests++;
            if ({out_valid, filled, sum, q} !== exp) begin
                n_fail++;
                $display("FAIL fill[%0d]: got ov=%b fl=%b sum=%0d q=%0d, want %h", i, out_valid,
                         filled, sum, q, exp);
            end
        end
    endtask

    task automatic test_slide_idle;
        logic [19:0] exp;
        drive(1'b1, 8'd5, 1'b0);
        exp = pack(1'b1, 1'b1, 14);
        n_tests++;
        if ({out_valid, filled, sum, q} !== exp) begin
            n_fail++;
            $display("FAIL slide: got ov=%b fl=%b sum=%0d q=%0d, want %h", out_valid, filled,
                     sum, q, exp);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'd200, 1'b0);
            exp = pack(1'b0, 1'b1, 14);
            n_tests++;
            if ({out_valid, filled, sum, q} !== exp) begin
                n_fail++;
                $display("FAIL idle[%0d]: got ov=%b fl=%b sum=%0d q=%0d, want %h", i, out_valid,
                         filled, sum, q, exp);
            end
        end
    endtask

    task automatic test_gapped;
        logic vs [7]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   sums [7] = '{7, 7, 14, 14, 14, 21, 28};
        logic [19:0] exp;
        drive(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(vs[i], 8'd7, 1'b0);
            exp = pack(i == 6, i == 6, sums[i]);
            n_tests++;
            if ({out_valid, filled, sum, q} !== exp) begin
                n_fail++;
                $display("FAIL gapped[%0d]: got ov=%b fl=%b sum=%0d q=%0d, want %h", i,
                         out_valid, filled, sum, q, exp);
            end
        end
    endtask

    task automatic test_max;
        logic [19:0] exp;
        drive(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd255, 1'b0);
        end
        exp = {1'b1, 1'b1, 10'd1020, 8'd255};
        n_tests++;
        if ({out_valid, filled, sum, q} !== exp) begin
            n_fail++;
            $display("FAIL max: got ov=%b fl=%b sum=%0d q=%0d, want %h", out_valid, filled,
                     sum, q, exp);
        end
    endtask

    task automatic test_clear;
        logic [19:0] exp;
        drive(1'b0, 8'd0, 1'b1);
        drive(1'b1, 8'd1, 1'b0);
        drive(1'b1, 8'd2, 1'b0);
        exp = pack(1'b0, 1'b0, 3);
        n_tests++;
        if ({out_valid, filled, sum, q} !== exp) begin
            n_fail++;
            $display("FAIL pre_clear: got ov=%b fl=%b sum=%0d q=%0d, want %h", out_valid,
                     filled, sum, q, exp);
        end
        drive(1'b1, 8'd99, 1'b1);
        exp = pack(1'b0, 1'b0, 0);
        n_tests++;
        if ({out_valid, filled, sum, q} !== exp) begin
            n_fail++;
            $display("FAIL clear: got ov=%b fl=%b sum=%0d q=%0d, want %h", out_valid, filled,
                     sum, q, exp);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd8, 1'b0);
            exp = pack(i == 3, i == 3, 8 * (i + 1));
            n_tests++;
            if ({out_valid, filled, sum, q} !== exp) begin
                n_fail++;
                $display("FAIL refill[%0d]: got ov=%b fl=%b sum=%0d q=%0d, want %h", i,
                         out_valid, filled, sum, q, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [19:0] exp;
        drive(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd10, 1'b0);
        end
        exp = pack(1'b1, 1'b1, 40);
        n_tests++;
        if ({out_valid, filled, sum, q} !== exp) begin
            n_fail++;
            $display("FAIL full40: got ov=%b fl=%b sum=%0d q=%0d, want %h", out_valid, filled,
                     sum, q, exp);
        end
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        exp = pack(1'b0, 1'b0, 0);
        n_tests++;
        if ({out_valid, filled, sum, q} !== exp) begin
            n_fail++;
            $display("FAIL mid_reset: got ov=%b fl=%b sum=%0d q=%0d, want %h", out_valid,
                     filled, sum, q, exp);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd10, 1'b0);
            exp = pack(i == 3, i == 3, 10 * (i + 1));
            n_tests++;
            if ({out_valid, filled, sum, q} !== exp) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got ov=%b fl=%b sum=%0d q=%0d, want %h", i,
                         out_valid, filled, sum, q, exp);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        d        = 8'd0;
        clear    = 1'b0;
        test_reset();
        test_fill();
        test_slide_idle();
        test_gapped();
        test_max();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
